// File: rtl/factory_test_pkg.sv
// Shared definitions for the factory test-pattern generator: mode encoding and LFSR taps.
// Tap constants are only consumed when FACTORY_TEST_LFSR_EN is defined.
package factory_test_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2,
    MODE_LFSR = 2'd3
  } mode_e;

  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_D008;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsrTaps(input int w);
    case (w)
      8:       lfsrTaps = LFSR_TAPS_8;
      16:      lfsrTaps = LFSR_TAPS_16;
      32:      lfsrTaps = LFSR_TAPS_32;
      default: lfsrTaps = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/factory_test_prescaler.sv
// Free-running prescaler: counts 0..div and flags an advance in the cycle it reaches div.
module factory_test_prescaler #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             adv
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign adv = (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || adv) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/factory_test_pattern.sv
// Factory test-pattern generator with pad output enable and loopback checker.
// Define FACTORY_TEST_LFSR_EN to enable the LFSR pattern mode (otherwise mode 3 counts up).
module factory_test_pattern
  import factory_test_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] loop_i,
  input  logic             chk_en_i,
  output logic [WIDTH-1:0] pat_o,
  output logic [WIDTH-1:0] oe_o,
  output logic             tick_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

`ifdef FACTORY_TEST_LFSR_EN
  if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : gBadWidth
    $error("factory_test_pattern: LFSR mode supports WIDTH 8, 16 or 32 only");
  end
`else
  if (WIDTH < 2) begin : gBadWidth
    $error("factory_test_pattern: WIDTH must be at least 2");
  end
`endif

  mode_e            mode_q, modeIn;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] errCnt_q, errCnt_d;
  logic [WIDTH-1:0] startVal, stepVal, loadVal;
  logic             modeChange, inPass, preClr, adv, mismatch;

  assign modeIn     = mode_e'(mode_i);
  assign modeChange = (modeIn != mode_q);
  assign inPass     = (mode_q == MODE_PASS);

  factory_test_prescaler #(
    .DIV_W(DIV_W)
  ) uPrescaler (
    .clk(clk),
    .rst(rst),
    .clr(preClr),
    .div(div_i),
    .adv(adv)
  );

`ifdef FACTORY_TEST_LFSR_EN
  localparam logic [31:0] TAPS = lfsrTaps(WIDTH);
  logic fb;
  assign fb = ^(pat_q & TAPS[WIDTH-1:0]);
`endif

  // Candidate next values for each source, then resolve by priority.
  always_comb begin
    startVal = '0;
    if (modeIn == MODE_PASS) begin
      startVal = loop_i;
    end
`ifdef FACTORY_TEST_LFSR_EN
    if (modeIn == MODE_LFSR) begin
      startVal = WIDTH'(1);
    end
`endif

    case (mode_q)
      MODE_DOWN: stepVal = pat_q - 1'b1;
`ifdef FACTORY_TEST_LFSR_EN
      MODE_LFSR: stepVal = {pat_q[WIDTH-2:0], fb};
`endif
      default:   stepVal = pat_q + 1'b1;
    endcase

    loadVal = load_val_i;
`ifdef FACTORY_TEST_LFSR_EN
    // The all-zero state is a lock-up for the LFSR.
    if (mode_q == MODE_LFSR && load_val_i == '0) begin
      loadVal = WIDTH'(1);
    end
`endif

    pat_d  = pat_q;
    tick_d = 1'b0;
    preClr = 1'b0;
    if (modeChange) begin
      pat_d  = startVal;
      preClr = 1'b1;
    end else if (inPass) begin
      pat_d  = loop_i;
      preClr = 1'b1;
    end else if (load_i) begin
      pat_d  = loadVal;
      preClr = 1'b1;
    end else if (adv) begin
      pat_d  = stepVal;
      tick_d = 1'b1;
    end

    mismatch = chk_en_i && !inPass && !modeChange && (loop_i != pat_q);
    err_d    = err_q | mismatch;
    errCnt_d = errCnt_q;
    if (mismatch && errCnt_q != '1) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_PASS;
      pat_q    <= '0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
      errCnt_q <= '0;
    end else begin
      mode_q   <= modeIn;
      pat_q    <= pat_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
    end
  end

  assign pat_o     = pat_q;
  assign oe_o      = inPass ? '0 : '1;
  assign tick_o    = tick_q;
  assign err_o     = err_q;
  assign err_cnt_o = errCnt_q;

endmodule
